health_ctrl: RTL
================

# health_ctrl

Player health controller sitting directly upstream of the heart-sprite renderer. Converts raw collision, pickup and restart events into a saturating heart count (0..3), with a post-hit invulnerability window, a blink flag for the player sprite, and a game-over flag. The heart count presented to the renderer is frame-synchronous, so hearts never change mid-frame.

## Interface
Parameters:
- MAX_HEARTS, 3: full-health count; must fit in 2 bits (1..3).
- INVULN_FRAMES, 90: length of the post-hit invulnerability window, in frame ticks.
- BLINK_FRAMES, 8: half-period of the blink flag, in frame ticks.

Ports:
- clk, input, 1: system (pixel) clock.
- reset, input, 1: synchronous, active-high.
- frame_tick, input, 1: one-cycle pulse, once per frame at end of the visible area.
- collision, input, 1: level from the collision detector, high while the player overlaps an enemy.
- heal, input, 1: one-cycle pulse on heart pickup.
- restart, input, 1: one-cycle pulse from the game-over screen logic.
- num_hearts, output, 2: frame-synchronous heart count to the renderer.
- game_over, output, 1: high while in DEAD.
- invuln, output, 1: high while in INVULN.
- player_blink, output, 1: sprite hide flag; toggles during INVULN, 0 otherwise.
- hit_pulse, output, 1: one-cycle pulse on each accepted hit (drives the sound/effect stage).

## Operation
- Internal registers:
  - health: 2 bits.
  - state: ALIVE, INVULN or DEAD.
  - inv_cnt: width $clog2(INVULN_FRAMES+1).
  - blink_cnt: width $clog2(BLINK_FRAMES).
  - col_d: previous collision sample.
- Hit event: collision & ~col_d (rising edge). A held collision level counts once.
- ALIVE:
  - Hit with health > 1: health decrements, inv_cnt loads INVULN_FRAMES, blink_cnt clears, player_blink is set to 1, hit_pulse fires, state goes to INVULN.
  - Hit with health == 1: health goes to 0, hit_pulse fires, state goes to DEAD.
- INVULN:
  - Hits are ignored; there is no hit_pulse.
  - On each frame_tick, inv_cnt decrements and blink_cnt advances.
  - When blink_cnt wraps at BLINK_FRAMES-1, player_blink toggles.
  - A frame_tick with inv_cnt == 1 moves the state to ALIVE and clears player_blink.
- DEAD:
  - health is held at 0; hits and heal are ignored.
  - restart loads health with MAX_HEARTS and moves the state to ALIVE.
  - restart in any other state is ignored.
- heal, in ALIVE or INVULN: health increments, saturating at MAX_HEARTS. It does not change state or inv_cnt.
- Simultaneous hit and heal in ALIVE: the hit wins and heal is dropped that cycle.
- Simultaneous heal and frame_tick: both take effect.
- num_hearts loads health on frame_tick only, with one exception: entering DEAD also forces num_hearts to 0 immediately.
- game_over = (state == DEAD) and is registered. invuln = (state == INVULN).

## Timing
- Reset values (all take effect on the next clk edge with reset high, overriding any input):
  - health and num_hearts = MAX_HEARTS.
  - state = ALIVE.
  - game_over, invuln, player_blink, hit_pulse = 0.
  - inv_cnt, blink_cnt, col_d = 0.
- Reset asserted mid-INVULN or in DEAD returns the block to the reset values on that edge.
- Every output is a flop; there is no combinational input-to-output path.
- Hit latency:
  - collision first sampled high at edge n; hit_pulse, health, state and invuln change at edge n+1.
  - num_hearts follows on the first frame_tick sampled after that.
  - If that hit is fatal, num_hearts and game_over are both 0/1 at edge n+1.
- INVULN length is exactly INVULN_FRAMES frame_ticks, counted from the first frame_tick after entry.
- A collision still held high when INVULN ends is not a new hit; a fresh rising edge is required.
- heal is visible in health at the next edge and in num_hearts at the next frame_tick.

## Structure
- health_pkg holds:
  - the state enum (ALIVE, INVULN, DEAD);
  - the HEART_W = 2 constant;
  - the default MAX_HEARTS, INVULN_FRAMES and BLINK_FRAMES.
- One sub-module, edge_rise, provides the registered rising-edge detector used for collision; it is reusable for the button inputs elsewhere.
- Everything else lives in a single always block for the FSM and counters, plus the num_hearts shadow register.

## Test plan
- Reset, then 3 frame_ticks with no events -> num_hearts=3, game_over=0, invuln=0, player_blink=0.
- Collision held high for 200 frames, INVULN_FRAMES=90 -> exactly one hit_pulse; health 2; invuln high for 90 ticks; player_blink toggles every 8 ticks; no second hit after INVULN ends.
- Three separated collisions, each after INVULN expires -> num_hearts 3→2→1→0 at frame_ticks; game_over=1 on the third hit +1 cycle, before any frame_tick.
- Hit and heal in the same cycle at health 3 -> health 2, state INVULN. Then two heal pulses -> health 3, saturated, inv_cnt unaffected.
- In DEAD: heal and collision -> no change. restart -> health 3, state ALIVE, game_over=0 next cycle, num_hearts=3 at next frame_tick.
- Reset asserted mid-INVULN (inv_cnt=40) -> next edge: health and num_hearts 3, invuln 0, player_blink 0.

Source files
------------

// File: rtl/health_pkg.sv
// Shared types and default parameters for the player health controller.
package health_pkg;

    localparam int HEART_W = 2;

    localparam int DEFAULT_MAX_HEARTS    = 3;
    localparam int DEFAULT_INVULN_FRAMES = 90;
    localparam int DEFAULT_BLINK_FRAMES  = 8;

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } state_t;

endpackage

// File: rtl/health_edge_rise.sv
// Registered rising-edge detector: one-cycle pulse the cycle after din first
// samples high. Reusable for button inputs.
module edge_rise (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic din_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            din_d <= 1'b0;
            rise  <= 1'b0;
        end else begin
            din_d <= din;
            rise  <= din & ~din_d;
        end
    end

endmodule

// File: rtl/health_ctrl.sv
// Player health controller: saturating heart count, post-hit invulnerability
// with sprite blink, game-over flag, and a frame-synchronous heart count.
module health_ctrl
    import health_pkg::*;
#(
    parameter int MAX_HEARTS    = DEFAULT_MAX_HEARTS,
    parameter int INVULN_FRAMES = DEFAULT_INVULN_FRAMES,
    parameter int BLINK_FRAMES  = DEFAULT_BLINK_FRAMES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               collision,
    input  logic               heal,
    input  logic               restart,
    output logic [HEART_W-1:0] num_hearts,
    output logic               game_over,
    output logic               invuln,
    output logic               player_blink,
    output logic               hit_pulse
);

    localparam int INV_W = $clog2(INVULN_FRAMES + 1);
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [HEART_W-1:0] FULL      = HEART_W'(MAX_HEARTS);
    localparam logic [HEART_W-1:0] ONE_HEART = HEART_W'(1);
    localparam logic [INV_W-1:0]   INV_LOAD  = INV_W'(INVULN_FRAMES);
    localparam logic [INV_W-1:0]   INV_ONE   = INV_W'(1);
    localparam logic [BLK_W-1:0]   BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);
    localparam logic [BLK_W-1:0]   BLK_ONE   = BLK_W'(1);

    state_t             state;
    logic [HEART_W-1:0] health;
    logic [INV_W-1:0]   inv_cnt;
    logic [BLK_W-1:0]   blink_cnt;
    logic               hit;

    edge_rise u_col_edge (
        .clk   (clk),
        .reset (reset),
        .din   (collision),
        .rise  (hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ALIVE;
            health       <= FULL;
            num_hearts   <= FULL;
            inv_cnt      <= '0;
            blink_cnt    <= '0;
            game_over    <= 1'b0;
            invuln       <= 1'b0;
            player_blink <= 1'b0;
            hit_pulse    <= 1'b0;
        end else begin
            hit_pulse <= 1'b0;
            // Renderer only sees health changes at frame boundaries.
            if (frame_tick)
                num_hearts <= health;

            case (state)
                ALIVE: begin
                    if (hit) begin
                        hit_pulse <= 1'b1;
                        if (health > ONE_HEART) begin
                            health       <= health - ONE_HEART;
                            inv_cnt      <= INV_LOAD;
                            blink_cnt    <= '0;
                            player_blink <= 1'b1;
                            invuln       <= 1'b1;
                            state        <= INVULN;
                        end else begin
                            // Fatal hit bypasses the frame-synchronous update.
                            health     <= '0;
                            num_hearts <= '0;
                            game_over  <= 1'b1;
                            state      <= DEAD;
                        end
                    end else if (heal && health < FULL) begin
                        health <= health + ONE_HEART;
                    end
                end

                INVULN: begin
                    if (heal && health < FULL)
                        health <= health + ONE_HEART;
                    if (frame_tick) begin
                        inv_cnt <= inv_cnt - INV_ONE;
                        if (inv_cnt == INV_ONE) begin
                            invuln       <= 1'b0;
                            player_blink <= 1'b0;
                            state        <= ALIVE;
                        end else if (blink_cnt == BLK_LAST) begin
                            blink_cnt    <= '0;
                            player_blink <= ~player_blink;
                        end else begin
                            blink_cnt <= blink_cnt + BLK_ONE;
                        end
                    end
                end

                DEAD: begin
                    if (restart) begin
                        health    <= FULL;
                        game_over <= 1'b0;
                        state     <= ALIVE;
                    end
                end

                default: state <= ALIVE;
            endcase
        end
    end

endmodule
